mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding, grant owner codes and the legal parameter ranges that size the
// internal counters.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int MEM_LAT_MIN    = 1;
    localparam int MEM_LAT_MAX    = 4;
    localparam int MAX_STREAK_MIN = 1;
    localparam int MAX_STREAK_MAX = 15;

    // Counter widths derived from the largest legal parameter values.
    localparam int LAT_W    = $clog2(MEM_LAT_MAX + 1);
    localparam int STREAK_W = $clog2(MAX_STREAK_MAX + 1);

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side bus of the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters and the memory model that surround it.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic        busy;
    logic        owner;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_cs, mem_oe, mem_we, mem_addr, mem_din, busy, owner
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_cs, mem_oe, mem_we, mem_addr, mem_din, busy, owner
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by an instruction fetch port and a data
// port. Data wins by default; after MAX_STREAK back-to-back data grants with
// a fetch waiting, the fetch is forced through. Each access takes one IDLE
// grant cycle, MEM_LAT ACCESS cycles and one ACK cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    state_t                state;
    state_t                state_next;
    logic [LAT_W-1:0]      lat_cnt;
    logic [STREAK_W-1:0]   streak;
    logic                  owner_q;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [31:0]           din_q;
    logic [31:0]           if_rdata_q;
    logic [31:0]           d_rdata_q;

    logic                  any_req;
    logic                  grant_d;
    logic                  last_access;

    // Arbitration: data is favoured unless the streak limit is hit while a fetch waits.
    always_comb begin
        any_req     = bus.if_req | bus.d_req;
        grant_d     = bus.d_req && !(bus.if_req && (streak == STREAK_W'(MAX_STREAK)));
        last_access = (state == ST_ACCESS) && (lat_cnt == '0);
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory/handshake outputs, all decoded from registered state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_next   = state;
        bus.mem_cs   = 1'b1;
        bus.mem_oe   = 1'b1;
        bus.mem_we   = 1'b0;
        bus.if_ack   = 1'b0;
        bus.d_ack    = 1'b0;
        bus.busy     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (any_req) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                bus.busy   = 1'b1;
                bus.mem_cs = 1'b0;
                bus.mem_oe = we_q;
                bus.mem_we = we_q && (lat_cnt == '0);
                if (lat_cnt == '0) state_next = ST_ACK;
            end
            ST_ACK: begin
                bus.busy   = 1'b1;
                bus.if_ack = (owner_q == OWN_IF);
                bus.d_ack  = (owner_q == OWN_D);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Grant-time latching of operands, latency/streak counters and read capture.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the read-data registers are architecturally visible and must
        // read as zero out of reset, so they are reset like control flops.
        if (!reset) begin
            lat_cnt    <= '0;
            streak     <= '0;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (state == ST_IDLE && any_req) begin
                lat_cnt <= LAT_W'(MEM_LAT - 1);
                if (grant_d) begin
                    owner_q <= OWN_D;
                    we_q    <= bus.d_we;
                    addr_q  <= bus.d_addr;
                    din_q   <= bus.d_wdata;
                    streak  <= bus.if_req ? streak + 1'b1 : '0;
                end else begin
                    owner_q <= OWN_IF;
                    we_q    <= 1'b0;
                    addr_q  <= bus.if_addr;
                    streak  <= '0;
                end
            end else if (state == ST_ACCESS && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (last_access && !we_q) begin
                if (owner_q == OWN_D) d_rdata_q  <= bus.mem_dout;
                else                  if_rdata_q <= bus.mem_dout;
            end
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.owner    = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Three instances with MEM_LAT = 1, 2, 3 share
// clock and reset. Cycle 0 of a transaction is the IDLE cycle in which the
// request is first presented; ACCESS occupies cycles 1..MEM_LAT and the ack
// appears in cycle MEM_LAT+1. Inputs change and outputs are sampled 1 time
// unit after each rising edge.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if bus1 ();
    mem_arbiter_if bus2 ();
    mem_arbiter_if bus3 ();

    mem_arbiter #(.MEM_LAT(1), .MAX_STREAK(4)) u_lat1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_arbiter #(.MEM_LAT(2), .MAX_STREAK(4)) u_lat2 (.clk(clk), .reset(reset), .bus(bus2));
    mem_arbiter #(.MEM_LAT(3), .MAX_STREAK(4)) u_lat3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        {bus1.if_req, bus1.d_req, bus1.d_we} = '0;
        {bus2.if_req, bus2.d_req, bus2.d_we} = '0;
        {bus3.if_req, bus3.d_req, bus3.d_we} = '0;
        bus1.if_addr = '0; bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_dout = '0;
        bus2.if_addr = '0; bus2.d_addr = '0; bus2.d_wdata = '0; bus2.mem_dout = '0;
        bus3.if_addr = '0; bus3.d_addr = '0; bus3.d_wdata = '0; bus3.mem_dout = '0;

        // Reset values.
        repeat (2) next_cycle();
        check("rst_mem_cs",   32'(bus1.mem_cs),   32'd1);
        check("rst_mem_oe",   32'(bus1.mem_oe),   32'd1);
        check("rst_mem_we",   32'(bus1.mem_we),   32'd0);
        check("rst_mem_addr", bus1.mem_addr,      32'd0);
        check("rst_mem_din",  bus1.mem_din,       32'd0);
        check("rst_if_rdata", bus1.if_rdata,      32'd0);
        check("rst_d_rdata",  bus1.d_rdata,       32'd0);
        check("rst_acks",     32'({bus1.if_ack, bus1.d_ack}), 32'd0);
        check("rst_busy",     32'(bus1.busy),     32'd0);
        check("rst_owner",    32'(bus1.owner),    32'd0);
        reset = 1'b1;
        next_cycle();

        // Fetch on MEM_LAT=1.
        bus1.if_req = 1'b1; bus1.if_addr = 32'h10; bus1.mem_dout = 32'h8C22_0004;
        check("f1_c0_busy", 32'(bus1.busy), 32'd0);
        next_cycle();
        check("f1_c1_cs",    32'(bus1.mem_cs), 32'd0);
        check("f1_c1_oe",    32'(bus1.mem_oe), 32'd0);
        check("f1_c1_addr",  bus1.mem_addr,    32'h10);
        check("f1_c1_owner", 32'(bus1.owner),  32'd0);
        check("f1_c1_ack",   32'(bus1.if_ack), 32'd0);
        next_cycle();
        check("f1_c2_ack",   32'(bus1.if_ack), 32'd1);
        check("f1_c2_rdata", bus1.if_rdata,    32'h8C22_0004);
        check("f1_c2_cs",    32'(bus1.mem_cs), 32'd1);
        bus1.if_req = 1'b0; bus1.mem_dout = 32'h0;
        next_cycle();
        check("f1_c3_ack",   32'(bus1.if_ack), 32'd0);
        check("f1_c3_hold",  bus1.if_rdata,    32'h8C22_0004);
        check("f1_c3_busy",  32'(bus1.busy),   32'd0);

        // Store on MEM_LAT=3.
        bus3.d_req = 1'b1; bus3.d_we = 1'b1; bus3.d_addr = 32'h40; bus3.d_wdata = 32'hDEAD_BEEF;
        next_cycle();
        check("st_c1_we",    32'(bus3.mem_we), 32'd0);
        check("st_c1_oe",    32'(bus3.mem_oe), 32'd1);
        check("st_c1_cs",    32'(bus3.mem_cs), 32'd0);
        check("st_c1_din",   bus3.mem_din,     32'hDEAD_BEEF);
        check("st_c1_addr",  bus3.mem_addr,    32'h40);
        check("st_c1_owner", 32'(bus3.owner),  32'd1);
        next_cycle();
        check("st_c2_we",    32'(bus3.mem_we), 32'd0);
        check("st_c2_ack",   32'(bus3.d_ack),  32'd0);
        next_cycle();
        check("st_c3_we",    32'(bus3.mem_we), 32'd1);
        check("st_c3_oe",    32'(bus3.mem_oe), 32'd1);
        check("st_c3_ack",   32'(bus3.d_ack),  32'd0);
        next_cycle();
        check("st_c4_ack",   32'(bus3.d_ack),  32'd1);
        check("st_c4_we",    32'(bus3.mem_we), 32'd0);
        check("st_c4_rdata", bus3.d_rdata,     32'd0);
        bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        next_cycle();
        check("st_c5_ack",   32'(bus3.d_ack),  32'd0);

        // Simultaneous fetch and load on MEM_LAT=2: data first, then fetch.
        bus2.if_req = 1'b1; bus2.if_addr = 32'h100;
        bus2.d_req  = 1'b1; bus2.d_addr  = 32'h200; bus2.mem_dout = 32'h1111_1111;
        next_cycle();
        check("bo_c1_owner", 32'(bus2.owner),  32'd1);
        check("bo_c1_addr",  bus2.mem_addr,    32'h200);
        check("bo_c1_oe",    32'(bus2.mem_oe), 32'd0);
        next_cycle();
        check("bo_c2_ack",   32'({bus2.if_ack, bus2.d_ack}), 32'd0);
        next_cycle();
        check("bo_c3_dack",  32'(bus2.d_ack),  32'd1);
        check("bo_c3_iack",  32'(bus2.if_ack), 32'd0);
        check("bo_c3_rdata", bus2.d_rdata,     32'h1111_1111);
        bus2.d_req = 1'b0; bus2.mem_dout = 32'h2222_2222;
        next_cycle();
        check("bo_c4_busy",  32'(bus2.busy),   32'd0);
        next_cycle();
        check("bo_c5_owner", 32'(bus2.owner),  32'd0);
        check("bo_c5_addr",  bus2.mem_addr,    32'h100);
        next_cycle();
        check("bo_c6_iack",  32'(bus2.if_ack), 32'd0);
        next_cycle();
        check("bo_c7_iack",  32'(bus2.if_ack), 32'd1);
        check("bo_c7_irdat", bus2.if_rdata,    32'h2222_2222);
        check("bo_c7_dhold", bus2.d_rdata,     32'h1111_1111);
        bus2.if_req = 1'b0;
        next_cycle();
        check("bo_c8_iack",  32'(bus2.if_ack), 32'd0);

        // Streak limit on MEM_LAT=1: four data grants, then the fetch.
        bus1.if_req = 1'b1; bus1.if_addr = 32'h300;
        bus1.d_req  = 1'b1; bus1.d_addr  = 32'h400; bus1.d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus1.mem_dout = 32'hA0 + 32'(k);
            next_cycle();
            check($sformatf("sk%0d_owner", k), 32'(bus1.owner), 32'd1);
            next_cycle();
            check($sformatf("sk%0d_dack", k),  32'(bus1.d_ack), 32'd1);
            check($sformatf("sk%0d_rdata", k), bus1.d_rdata,    32'hA0 + 32'(k));
            next_cycle();
        end
        bus1.mem_dout = 32'h5555_AAAA;
        next_cycle();
        check("sk4_owner", 32'(bus1.owner), 32'd0);
        check("sk4_addr",  bus1.mem_addr,   32'h300);
        next_cycle();
        check("sk4_iack",  32'(bus1.if_ack), 32'd1);
        check("sk4_dack",  32'(bus1.d_ack),  32'd0);
        check("sk4_rdata", bus1.if_rdata,    32'h5555_AAAA);
        bus1.if_req = 1'b0; bus1.d_req = 1'b0;
        next_cycle();

        // Asynchronous reset in the final ACCESS cycle of a store (MEM_LAT=3).
        bus3.d_req = 1'b1; bus3.d_we = 1'b1; bus3.d_addr = 32'h80; bus3.d_wdata = 32'h1234_5678;
        repeat (3) next_cycle();
        check("ra_we_pre", 32'(bus3.mem_we), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("ra_we",    32'(bus3.mem_we), 32'd0);
        check("ra_cs",    32'(bus3.mem_cs), 32'd1);
        check("ra_oe",    32'(bus3.mem_oe), 32'd1);
        check("ra_addr",  bus3.mem_addr,    32'd0);
        check("ra_din",   bus3.mem_din,     32'd0);
        check("ra_busy",  32'(bus3.busy),   32'd0);
        check("ra_owner", 32'(bus3.owner),  32'd0);
        next_cycle();
        check("ra_dack",  32'(bus3.d_ack),  32'd0);
        check("ra_d_rd",  bus3.d_rdata,     32'd0);
        bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        reset = 1'b1;
        next_cycle();
        check("ra_idle_dack", 32'(bus3.d_ack), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
